bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port din_valid  input  1  din holds a valid word.
REQ-007 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port sout  output  1  serial bit; drives the pattern detector's serial input.
REQ-009 SHALL have port sout_valid  output  1  sout carries a word bit this cycle.
REQ-010 SHALL have port word_done  output  1  one-cycle pulse while the last bit of a word is on sout.
REQ-011 SHALL have port busy  output  1  a word is shifting or the hold register is full.

Function
REQ-012 SHALL accept a word on any rising edge where din_valid and din_ready are both 1.
REQ-013 SHALL contain a WIDTH-bit shift register, a bit counter and a one-entry hold register.
REQ-014 SHALL drive din_ready = !hold_full && !rst, combinationally from registered state.
REQ-015 SHALL use two states: IDLE (shifter empty) and SHIFT (shifter loaded).
REQ-016 IDLE, word accepted: SHALL load it into the shifter, clear the counter and move to SHIFT; first bit appears on sout the cycle after the accepting edge (latency 1).
REQ-017 SHIFT: SHALL present exactly one bit per cycle with sout_valid=1, order per MSB_FIRST, and increment the counter.
REQ-018 SHIFT, not last bit, word accepted: SHALL store the word in the hold register.
REQ-019 Last bit (counter = WIDTH-1): SHALL assert word_done for that cycle.
REQ-020 Last bit, hold full: SHALL move hold into the shifter, clear hold, remain in SHIFT.
REQ-021 Last bit, hold empty, word accepted: SHALL load that word straight into the shifter and remain in SHIFT.
REQ-022 Last bit, hold empty, no accept: SHALL return to IDLE.
REQ-023 Gap rule: a word available before the previous last bit SHALL start on the next cycle with no bubble.
REQ-024 SHALL drive sout=0 whenever sout_valid=0.
REQ-025 SHALL assert busy in SHIFT or when hold_full=1, and deassert it otherwise.
REQ-026 SHALL drop no accepted word and duplicate no bit.

Reset
REQ-027 On any edge with rst=1, SHALL force state IDLE, counter 0, hold_full 0, shifter and hold cleared.
REQ-028 While rst=1, SHALL hold sout=0, sout_valid=0, word_done=0, busy=0 and din_ready=0.
REQ-029 Reset mid-word SHALL discard both shifter and hold contents; from the next cycle sout_valid=0 and no further bits of those words are emitted.
REQ-030 SHALL drive din_ready=1 on the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the state encoding (IDLE=0, SHIFT=1) and the WIDTH default in shared package bit_serializer_pkg.
REQ-032 SHALL implement the one-entry hold register (data, full flag, load and take strobes) as sub-module ser_hold_reg; all other logic SHALL be inline.
REQ-033 SHALL size the counter as $clog2(WIDTH) bits and SHALL infer no latches.

Verification
REQ-034 Reset: rst=1 for 3 cycles with din_valid=1, din=8'hFF -> sout_valid=0, din_ready=0 throughout; nothing emitted after release.
REQ-035 Single word, WIDTH=8: din=8'hB0 accepted at edge N -> sout=1,0,1,1,0,0,0,0 on cycles N+1..N+8, word_done at N+8, IDLE at N+9; chained detector pulses once.
REQ-036 Back-to-back: 8'hB0 then 8'h0B with din_valid held -> 16 contiguous bits with sout_valid=1, din_ready=0 while hold full, word_done at bits 8 and 16.
REQ-037 Last-bit accept: second word offered exactly on the first word's last-bit cycle with hold empty -> accepted and its first bit follows immediately, with no gap.
REQ-038 Reset mid-word: rst pulsed after the 3rd bit of 8'hB0 with 8'h0B held -> sout_valid=0 next cycle; neither word's remaining bits appear.
REQ-039 LSB-first: MSB_FIRST=0, din=8'h0D -> sout=1,0,1,1,0,0,0,0.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: state encoding and default word width.
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry hold register that parks a word accepted while the shifter is still busy.
module ser_hold_reg #(
  parameter int WIDTH = bit_serializer_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  // The parent never loads and takes in the same cycle, so load simply wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (take) begin
      dout <= '0;
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer so consecutive words
// stream out without a gap.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e       state, next_state;
  logic [WIDTH-1:0] shreg, next_shreg;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, hold_load, hold_take;
  logic             accept, last_bit, cur_bit;

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .take (hold_take),
    .din  (din),
    .dout (hold_data),
    .full (hold_full)
  );

  // Outputs are masked by rst so the port is quiet during the reset cycle itself.
  assign din_ready  = !hold_full && !rst;
  assign accept     = din_valid && din_ready;
  assign last_bit   = (state == SHIFT) && (cnt == LAST_CNT);
  assign cur_bit    = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign sout_valid = (state == SHIFT) && !rst;
  assign sout       = sout_valid && cur_bit;
  assign word_done  = last_bit && !rst;
  assign busy       = ((state == SHIFT) || hold_full) && !rst;

  always_comb begin
    next_state = state;
    next_shreg = shreg;
    next_cnt   = cnt;
    hold_load  = 1'b0;
    hold_take  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_shreg = din;
          next_cnt   = '0;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Refill from hold first, then from the port, else drain to idle.
          next_cnt = '0;
          if (hold_full) begin
            next_shreg = hold_data;
            hold_take  = 1'b1;
          end else if (accept) begin
            next_shreg = din;
          end else begin
            next_shreg = '0;
            next_state = IDLE;
          end
        end else begin
          next_cnt = cnt + 1'b1;
          if (MSB_FIRST != 0) next_shreg = {shreg[WIDTH-2:0], 1'b0};
          else                next_shreg = {1'b0, shreg[WIDTH-1:1]};
          hold_load = accept;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      shreg <= next_shreg;
      cnt   <= next_cnt;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Checks an MSB-first and an LSB-first serializer against a queue-of-bits model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         din_valid;
  logic [W-1:0] din;
  logic         ready_m, sout_m, sv_m, wd_m, busy_m;
  logic         ready_l, sout_l, sv_l, wd_l, busy_l;

  int checks = 0;
  int errors = 0;
  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready_m),
    .sout(sout_m), .sout_valid(sv_m), .word_done(wd_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready_l),
    .sout(sout_l), .sout_valid(sv_l), .word_done(wd_l), .busy(busy_l)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time,
               observed, expected);
    end
  endtask

  // The pending-bit queue is the model: its head is on sout, and more than one
  // word's worth of bits means a second word is parked.
  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d,
                               output bit acc);
    int   n;
    logic e_valid, e_ready, e_done, e_sm, e_sl;
    rst       = r;
    din_valid = v;
    din       = d;
    #1;
    n       = qm.size();
    e_valid = !r && (n > 0);
    e_ready = !r && (n <= W);
    e_done  = e_valid && ((n % W) == 1);
    e_sm    = 1'b0;
    e_sl    = 1'b0;
    if (e_valid) begin
      e_sm = qm[0];
      e_sl = ql[0];
    end
    checkOutput("msb_sout_valid", {31'd0, sv_m}, {31'd0, e_valid});
    checkOutput("msb_sout", {31'd0, sout_m}, {31'd0, e_sm});
    checkOutput("msb_word_done", {31'd0, wd_m}, {31'd0, e_done});
    checkOutput("msb_din_ready", {31'd0, ready_m}, {31'd0, e_ready});
    checkOutput("msb_busy", {31'd0, busy_m}, {31'd0, e_valid});
    checkOutput("lsb_sout_valid", {31'd0, sv_l}, {31'd0, e_valid});
    checkOutput("lsb_sout", {31'd0, sout_l}, {31'd0, e_sl});
    checkOutput("lsb_word_done", {31'd0, wd_l}, {31'd0, e_done});
    checkOutput("lsb_din_ready", {31'd0, ready_l}, {31'd0, e_ready});
    checkOutput("lsb_busy", {31'd0, busy_l}, {31'd0, e_valid});
    @(posedge clk);
    acc = 1'b0;
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (n > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (v && (n <= W)) begin
        for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
        for (int i = 0; i < W; i++) ql.push_back(d[i]);
        acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic sendWord(input logic [W-1:0] d);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      applyStimulus(1'b0, 1'b1, d, acc);
      tries++;
    end
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, '0, acc);
  endtask

  initial begin
    bit acc;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'hFF, acc);
    idle(3);

    sendWord(8'hB0);
    idle(10);

    sendWord(8'hB0);
    sendWord(8'h0B);
    idle(18);

    sendWord(8'hB0);
    idle(7);
    sendWord(8'h0B);
    idle(10);

    sendWord(8'hB0);
    sendWord(8'h0B);
    applyStimulus(1'b0, 1'b1, 8'h0B, acc);
    applyStimulus(1'b1, 1'b1, 8'h0B, acc);
    idle(10);

    sendWord(8'h0D);
    idle(10);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                    W'($urandom), acc);
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
